// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch front-panel controller.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUNNING = 3'd1,
    ST_PAUSED  = 3'd2,
    ST_LAP     = 3'd3,
    ST_ALARM   = 3'd4
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t MIN_MAX   = 4'd9;
  localparam bcd_t SECT_MAX  = 4'd5;
  localparam bcd_t SECO_MAX  = 4'd9;
  localparam bcd_t TENTH_MAX = 4'd9;

  // Packed M:ST:SO.T time words used for terminal-value comparisons.
  localparam logic [15:0] ZERO_TIME = 16'h0000;
  localparam logic [15:0] FULL_TIME = {MIN_MAX, SECT_MAX, SECO_MAX, TENTH_MAX};

endpackage

// File: rtl/button_conditioner.sv
// Raw push-button conditioning: 2-FF synchronizer, debounce, one-shot press event.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] CNT_MAX  = 4'(DEBOUNCE_CYCLES);

  logic       sync_p0;
  logic       sync_p1;
  logic [3:0] cnt;
  logic       level;
  logic       level_q;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
    end
  end

  // Debounced level rises on the DEBOUNCE_CYCLES-th consecutive high sample; any low clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= 4'd0;
      level <= 1'b0;
    end else if (!sync_p1) begin
      cnt   <= 4'd0;
      level <= 1'b0;
    end else begin
      if (cnt < CNT_MAX) cnt <= cnt + 4'd1;
      if (cnt >= CNT_LAST) level <= 1'b1;
    end
  end

  // Registered rising-edge detect so a held button yields a single event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_q <= level;
      press   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Front-panel controller: run/pause/lap/alarm sequencing and display selection.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int ALARM_CYCLES    = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_lap_clear,
  input  logic       mode_down,
  input  logic [3:0] sw_Minutes,
  input  logic [3:0] sw_SecondsTens,
  input  logic [3:0] sw_SecondsOnes,
  input  logic [3:0] sw_Tenths,
  output logic       Start,
  output logic       Stop,
  output logic       Clear,
  output logic       CountDown,
  output logic [3:0] disp_Minutes,
  output logic [3:0] disp_SecondsTens,
  output logic [3:0] disp_SecondsOnes,
  output logic [3:0] disp_Tenths,
  output logic       lap_active,
  output logic       alarm,
  output logic [2:0] state_dbg
);

  localparam int AW = $clog2(ALARM_CYCLES + 1);
  localparam logic [AW-1:0] ALARM_LOAD = AW'(ALARM_CYCLES - 1);

  state_t          state;
  state_t          state_next;
  logic            press_ss;
  logic            press_lc;
  logic            start_next;
  logic            stop_next;
  logic            clear_next;
  logic            count_down_next;
  logic            lap_active_next;
  logic            alarm_next;
  logic            lap_capture;
  logic [AW-1:0]   alarm_cnt;
  logic [AW-1:0]   alarm_cnt_next;
  logic [15:0]     live_time;
  logic [15:0]     live_q;
  logic [15:0]     lap_q;
  logic [15:0]     disp_time;
  logic            is_zero;
  logic            is_full;
  logic            terminal;
  logic            start_blocked;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_ss (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_start_stop),
    .press (press_ss)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_lc (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_lap_clear),
    .press (press_lc)
  );

  assign live_time     = {sw_Minutes, sw_SecondsTens, sw_SecondsOnes, sw_Tenths};
  assign is_zero       = (live_time == ZERO_TIME);
  assign is_full       = (live_time == FULL_TIME);
  assign terminal      = ((state == ST_RUNNING) || (state == ST_LAP)) &&
                         (CountDown ? is_zero : is_full);
  // Starting a countdown that is already at zero would alarm immediately, so refuse it.
  assign start_blocked = CountDown && is_zero;

  // Next-state and next-output logic; terminal detect outranks start_stop, which outranks lap_clear.
  always_comb begin
    state_next      = state;
    start_next      = 1'b0;
    stop_next       = 1'b0;
    clear_next      = 1'b0;
    count_down_next = CountDown;
    lap_active_next = lap_active;
    alarm_next      = alarm;
    alarm_cnt_next  = alarm_cnt;
    lap_capture     = 1'b0;
    case (state)
      ST_IDLE: begin
        count_down_next = mode_down;
        if (press_ss) begin
          if (!start_blocked) begin
            start_next = 1'b1;
            state_next = ST_RUNNING;
          end
        end else if (press_lc) begin
          clear_next = 1'b1;
        end
      end
      ST_RUNNING: begin
        if (terminal) begin
          stop_next       = 1'b1;
          lap_active_next = 1'b0;
          alarm_next      = 1'b1;
          alarm_cnt_next  = ALARM_LOAD;
          state_next      = ST_ALARM;
        end else if (press_ss) begin
          stop_next  = 1'b1;
          state_next = ST_PAUSED;
        end else if (press_lc) begin
          lap_capture     = 1'b1;
          lap_active_next = 1'b1;
          state_next      = ST_LAP;
        end
      end
      ST_LAP: begin
        if (terminal) begin
          stop_next       = 1'b1;
          lap_active_next = 1'b0;
          alarm_next      = 1'b1;
          alarm_cnt_next  = ALARM_LOAD;
          state_next      = ST_ALARM;
        end else if (press_ss) begin
          stop_next       = 1'b1;
          lap_active_next = 1'b0;
          state_next      = ST_PAUSED;
        end else if (press_lc) begin
          lap_active_next = 1'b0;
          state_next      = ST_RUNNING;
        end
      end
      ST_PAUSED: begin
        count_down_next = mode_down;
        if (press_ss) begin
          if (!start_blocked) begin
            start_next = 1'b1;
            state_next = ST_RUNNING;
          end
        end else if (press_lc) begin
          clear_next = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_ALARM: begin
        if ((alarm_cnt == '0) || press_ss || press_lc) begin
          alarm_next     = 1'b0;
          alarm_cnt_next = '0;
          state_next     = ST_IDLE;
        end else begin
          alarm_cnt_next = alarm_cnt - 1'b1;
        end
      end
      default: begin
        lap_active_next = 1'b0;
        alarm_next      = 1'b0;
        alarm_cnt_next  = '0;
        state_next      = ST_IDLE;
      end
    endcase
  end

  // State register plus registered control outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      Start      <= 1'b0;
      Stop       <= 1'b0;
      Clear      <= 1'b0;
      CountDown  <= 1'b0;
      lap_active <= 1'b0;
      alarm      <= 1'b0;
      alarm_cnt  <= '0;
    end else begin
      state      <= state_next;
      Start      <= start_next;
      Stop       <= stop_next;
      Clear      <= clear_next;
      CountDown  <= count_down_next;
      lap_active <= lap_active_next;
      alarm      <= alarm_next;
      alarm_cnt  <= alarm_cnt_next;
    end
  end

  // Display sources: one-cycle copy of live time and the lap snapshot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live_q <= 16'h0000;
      lap_q  <= 16'h0000;
    end else begin
      live_q <= live_time;
      if (lap_capture) lap_q <= live_time;
    end
  end

  assign disp_time        = lap_active ? lap_q : live_q;
  assign disp_Minutes     = disp_time[15:12];
  assign disp_SecondsTens = disp_time[11:8];
  assign disp_SecondsOnes = disp_time[7:4];
  assign disp_Tenths      = disp_time[3:0];
  assign state_dbg        = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: vector table plus directed corner sequences.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_ss = 1'b0;
  logic        btn_lc = 1'b0;
  logic        mode_down = 1'b0;
  logic [15:0] sw_time = 16'h0000;

  logic        Start, Stop, Clear, CountDown, lap_active, alarm;
  logic [3:0]  disp_Minutes, disp_SecondsTens, disp_SecondsOnes, disp_Tenths;
  logic [2:0]  state_dbg;
  logic [15:0] disp_time;

  int checks = 0;
  int failures = 0;

  assign disp_time = {disp_Minutes, disp_SecondsTens, disp_SecondsOnes, disp_Tenths};

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(2), .ALARM_CYCLES(30)) dut (
    .clk              (clk),
    .reset            (reset),
    .btn_start_stop   (btn_ss),
    .btn_lap_clear    (btn_lc),
    .mode_down        (mode_down),
    .sw_Minutes       (sw_time[15:12]),
    .sw_SecondsTens   (sw_time[11:8]),
    .sw_SecondsOnes   (sw_time[7:4]),
    .sw_Tenths        (sw_time[3:0]),
    .Start            (Start),
    .Stop             (Stop),
    .Clear            (Clear),
    .CountDown        (CountDown),
    .disp_Minutes     (disp_Minutes),
    .disp_SecondsTens (disp_SecondsTens),
    .disp_SecondsOnes (disp_SecondsOnes),
    .disp_Tenths      (disp_Tenths),
    .lap_active       (lap_active),
    .alarm            (alarm),
    .state_dbg        (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ss;
    logic        lc;
    logic        mode;
    logic [15:0] sw;
    logic [2:0]  exp_state;
    logic [2:0]  exp_pulse;
    logic        exp_lap;
    logic        exp_cd;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Hold the selected button(s) long enough to register, release, and let things settle.
  task automatic press(input logic ss, input logic lc, output logic [2:0] mask);
    mask = 3'b000;
    btn_ss = ss;
    btn_lc = lc;
    for (int i = 0; i < 8; i++) begin
      tick();
      mask |= {Start, Stop, Clear};
      check("pulse_onehot", 32'($countones({Start, Stop, Clear}) <= 1), 32'd1);
    end
    btn_ss = 1'b0;
    btn_lc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      mask |= {Start, Stop, Clear};
    end
  endtask

  initial begin
    logic [2:0] mask;
    int         n;
    int         pos;
    int         alarm_hi;
    logic       bad;

    vecs[0]  = '{1'b0, 1'b1, 1'b0, 16'h1234, 3'd0, 3'b001, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h1234, 3'd1, 3'b100, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'h1234, 3'd2, 3'b010, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'h1234, 3'd0, 3'b001, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 16'h1234, 3'd1, 3'b100, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'h1234, 3'd3, 3'b000, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h1234, 3'd1, 3'b000, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h1234, 3'd3, 3'b000, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'h1234, 3'd2, 3'b010, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 3'd2, 3'b000, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 16'h0005, 3'd1, 3'b100, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 16'h0005, 3'd2, 3'b010, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 16'h0005, 3'd0, 3'b001, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 16'h0000, 3'd0, 3'b000, 1'b0, 1'b1};

    // Reset state
    sw_time = 16'h1234;
    #2;
    check("reset_outputs", 32'({Start, Stop, Clear, CountDown, lap_active, alarm, state_dbg, disp_time}), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("idle_state", 32'(state_dbg), 32'd0);

    // One-cycle glitch produces nothing
    btn_ss = 1'b1;
    tick();
    btn_ss = 1'b0;
    mask = 3'b000;
    for (int i = 0; i < 8; i++) begin
      tick();
      mask |= {Start, Stop, Clear};
    end
    check("glitch_no_pulse", 32'(mask), 32'd0);
    check("glitch_state", 32'(state_dbg), 32'd0);

    // Held button: one Start, on cycle DEBOUNCE_CYCLES+3 = 5
    n = 0;
    pos = 0;
    btn_ss = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (Start) begin
        n++;
        pos = i;
      end
    end
    btn_ss = 1'b0;
    check("hold_start_count", 32'(n), 32'd1);
    check("hold_start_cycle", 32'(pos - 1), 32'd5);
    check("hold_state_running", 32'(state_dbg), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    check("live_disp", 32'(disp_time), 32'h1234);

    // Lap snapshot freezes the display while live time advances
    press(1'b0, 1'b1, mask);
    check("lap_no_pulse", 32'(mask), 32'd0);
    check("lap_state", 32'(state_dbg), 32'd3);
    check("lap_active_set", 32'(lap_active), 32'd1);
    sw_time = 16'h1235;
    tick();
    check("lap_frozen_a", 32'(disp_time), 32'h1234);
    sw_time = 16'h1236;
    tick();
    check("lap_frozen_b", 32'(disp_time), 32'h1234);
    press(1'b0, 1'b1, mask);
    check("unlap_state", 32'(state_dbg), 32'd1);
    check("unlap_lap_active", 32'(lap_active), 32'd0);
    sw_time = 16'h1240;
    check("live_delay_old", 32'(disp_time), 32'h1236);
    tick();
    check("live_delay_new", 32'(disp_time), 32'h1240);
    press(1'b1, 1'b0, mask);
    check("pause_stop", 32'(mask), 32'b010);
    press(1'b0, 1'b1, mask);
    check("paused_clear", 32'(mask), 32'b001);
    check("back_idle", 32'(state_dbg), 32'd0);

    // Transaction table
    for (int k = 0; k < 14; k++) begin
      mode_down = vecs[k].mode;
      sw_time = vecs[k].sw;
      tick();
      press(vecs[k].ss, vecs[k].lc, mask);
      check($sformatf("vec%0d_state", k), 32'(state_dbg), 32'(vecs[k].exp_state));
      check($sformatf("vec%0d_pulse", k), 32'(mask), 32'(vecs[k].exp_pulse));
      check($sformatf("vec%0d_lap", k), 32'(lap_active), 32'(vecs[k].exp_lap));
      check($sformatf("vec%0d_countdown", k), 32'(CountDown), 32'(vecs[k].exp_cd));
      check($sformatf("vec%0d_disp", k), 32'(disp_time), 32'(vecs[k].sw));
    end

    // Countdown reaching zero: Stop + alarm for 30 cycles, then IDLE without Clear
    sw_time = 16'h0001;
    tick();
    press(1'b1, 1'b0, mask);
    check("cd_start", 32'(mask), 32'b100);
    check("cd_running", 32'(state_dbg), 32'd1);
    sw_time = 16'h0000;
    tick();
    check("cd_term_stop", 32'(Stop), 32'd1);
    check("cd_term_alarm", 32'(alarm), 32'd1);
    check("cd_term_state", 32'(state_dbg), 32'd4);
    alarm_hi = 1;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (alarm) alarm_hi++;
      if (Clear || Start || Stop) bad = 1'b1;
    end
    check("alarm_length", 32'(alarm_hi), 32'd30);
    check("alarm_no_pulses", 32'(bad), 32'd0);
    check("alarm_to_idle", 32'(state_dbg), 32'd0);
    check("alarm_time_kept", 32'(disp_time), 32'h0000);

    // Up-count overflow with both presses landing on the terminal cycle
    mode_down = 1'b0;
    sw_time = 16'h9598;
    tick();
    tick();
    press(1'b1, 1'b0, mask);
    check("up_start", 32'(mask), 32'b100);
    btn_ss = 1'b1;
    btn_lc = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    sw_time = 16'h9599;
    tick();
    check("up_term_pulses", 32'({Start, Stop, Clear}), 32'b010);
    check("up_term_alarm", 32'(alarm), 32'd1);
    check("up_term_state", 32'(state_dbg), 32'd4);
    tick();
    check("up_presses_discarded", 32'({state_dbg, alarm, Stop, lap_active}), 32'({3'd4, 1'b1, 1'b0, 1'b0}));
    btn_ss = 1'b0;
    btn_lc = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("up_still_alarm", 32'(state_dbg), 32'd4);
    press(1'b1, 1'b0, mask);
    check("alarm_press_no_pulse", 32'(mask), 32'd0);
    check("alarm_press_idle", 32'({state_dbg, alarm}), 32'd0);

    // CountDown follows mode_down only in IDLE/PAUSED
    sw_time = 16'h0500;
    tick();
    press(1'b1, 1'b0, mask);
    check("mode_run_start", 32'(mask), 32'b100);
    mode_down = 1'b1;
    tick();
    tick();
    check("mode_held_running", 32'(CountDown), 32'd0);
    mode_down = 1'b0;
    press(1'b1, 1'b0, mask);
    check("mode_pause_stop", 32'(mask), 32'b010);
    mode_down = 1'b1;
    check("mode_paused_before", 32'(CountDown), 32'd0);
    tick();
    check("mode_paused_after", 32'(CountDown), 32'd1);
    sw_time = 16'h0000;
    press(1'b1, 1'b0, mask);
    check("zero_guard_paused", 32'({mask, state_dbg}), 32'({3'b000, 3'd2}));

    // Asynchronous reset while Start is high
    mode_down = 1'b0;
    sw_time = 16'h0100;
    tick();
    tick();
    btn_ss = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("pre_reset_start", 32'({Start, state_dbg}), 32'({1'b1, 3'd1}));
    reset = 1'b0;
    #1;
    check("async_reset_outputs", 32'({Start, Stop, Clear, CountDown, lap_active, alarm, state_dbg, disp_time}), 32'd0);
    btn_ss = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("post_reset_idle", 32'({state_dbg, Start}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Front-panel controller that sequences the Stopwatch datapath. It conditions two raw push-buttons and a mode switch, and runs the run/pause/lap/alarm state machine. It generates single-cycle Start/Stop/Clear pulses plus a held CountDown level, and drives the display: either live time or a frozen lap snapshot. It sits between the board I/O and Stopwatch on the same 10 Hz clock.

Parameters:
DEBOUNCE_CYCLES, 2, consecutive cycles a synchronized button must read high to count as pressed (1..15)
ALARM_CYCLES, 30, cycles the alarm output stays high before auto-return to IDLE (3 s at 10 Hz)

Ports:
clk  in  1  system clock (10 Hz)
reset  in  1  asynchronous, active-low reset (asserted at 0)
btn_start_stop  in  1  raw button, asynchronous to clk
btn_lap_clear  in  1  raw button, asynchronous to clk
mode_down  in  1  level switch: 1 = count down, 0 = count up
sw_Minutes, sw_SecondsTens, sw_SecondsOnes, sw_Tenths  in  4 each  live BCD time from Stopwatch
Start, Stop, Clear  out  1 each  single-cycle control pulses to Stopwatch
CountDown  out  1  direction level to Stopwatch
disp_Minutes, disp_SecondsTens, disp_SecondsOnes, disp_Tenths  out  4 each  display BCD
lap_active  out  1  display frozen
alarm  out  1  countdown reached zero, or up-count reached 9:59.9
state_dbg  out  3  current state encoding

Behaviour:
- Reset (async, reset=0): state IDLE. All outputs 0, including the disp_* values. Alarm counter 0. Any pulse in flight is dropped immediately.
- Button path: 2-FF synchronizer, then debounce counter.
  - The debounced level rises after DEBOUNCE_CYCLES consecutive high samples. Any low sample clears the counter and the level.
  - A one-cycle press event fires on the debounced level's rising edge. Holding the button gives one event only.
- Latency: the first clk edge that samples a raw high marks cycle 0. The control pulse is high on cycle DEBOUNCE_CYCLES+3. All outputs are registered.
- Same-cycle priority: zero/overflow detect, then start_stop press, then lap_clear press. Lower-priority events are discarded.
- At most one of Start/Stop/Clear is high in any cycle.
- CountDown tracks mode_down only in IDLE and PAUSED. It is held constant in RUNNING, LAP and ALARM.
- Terminal condition (T): in RUNNING or LAP, either of these:
  - CountDown=1 and the live time is 0:00.0;
  - CountDown=0 and the live time is 9:59.9.
- Transitions:
  - IDLE, start_stop: if CountDown=1 and live time is 0:00.0, ignore. Otherwise pulse Start and go to RUNNING.
  - IDLE, lap_clear: pulse Clear; stay in IDLE.
  - RUNNING, start_stop: pulse Stop; go to PAUSED.
  - RUNNING, lap_clear: snapshot the live time into the lap registers; set lap_active=1; go to LAP.
  - LAP, start_stop: pulse Stop; clear lap_active; go to PAUSED.
  - LAP, lap_clear: clear lap_active; go to RUNNING. No pulse is issued.
  - RUNNING/LAP, T: pulse Stop; clear lap_active; set alarm=1; load the alarm counter with ALARM_CYCLES-1; go to ALARM.
  - PAUSED, start_stop: same zero-guard as IDLE. Otherwise pulse Start and go to RUNNING.
  - PAUSED, lap_clear: pulse Clear; go to IDLE.
  - ALARM: the counter decrements each cycle. At 0, or on any press, clear alarm and go to IDLE. No Clear pulse is issued; the time stays at its terminal value.
- Display: disp_* shows the lap registers while lap_active=1. Otherwise it shows a registered copy of sw_* (one cycle of delay).
- State encoding: IDLE=0, RUNNING=1, PAUSED=2, LAP=3, ALARM=4. Codes 5-7 are illegal and recover to IDLE on the next edge.

Decomposition:
- Package stopwatch_pkg holds:
  - the state enum and its encodings;
  - BCD limit constants MIN_MAX=9, SECT_MAX=5, SECO_MAX=9, TENTH_MAX=9;
  - the 4-bit BCD digit type;
  - the zero-time and full-time comparison constants.
- One sub-module, button_conditioner (synchronizer, debounce, rising-edge event), parameterized by DEBOUNCE_CYCLES and instantiated twice.

Test Plan:
- Apply reset=0 mid-RUNNING while Start is high -> all outputs 0 in the same cycle, before any clk edge; state_dbg=0.
- DEBOUNCE_CYCLES=2, IDLE: hold btn_start_stop high 10 cycles -> exactly one Start pulse, on cycle 5; state_dbg=1. A 1-cycle glitch -> no pulse.
- RUNNING with sw time at 1:23.4, press lap_clear -> disp_* holds 1,2,3,4 while sw_* advances and lap_active=1. Press lap_clear again -> disp follows sw_* with 1-cycle delay.
- CountDown=1, RUNNING, sw steps 0:00.1 to 0:00.0 -> next cycle: Stop=1, alarm=1, state 4. Alarm stays high 30 cycles, then IDLE with no Clear.
- CountDown=0, RUNNING, sw reaches 9:59.9 -> Stop pulse, alarm=1. Start_stop and lap_clear presses in the same cycle as T -> presses are discarded.
- PAUSED: toggle mode_down 0→1 -> CountDown=1 next cycle. With sw at 0:00.0, start_stop is ignored. Toggle in RUNNING -> CountDown unchanged.
